// File: rtl/mem_access_pkg.sv
// Shared encodings and FSM state type for the load/store memory initiator.
package mem_access_pkg;

   localparam logic [1:0]  SIZE_BYTE = 2'b00;
   localparam logic [1:0]  SIZE_HALF = 2'b01;
   localparam logic [1:0]  SIZE_WORD = 2'b10;

   localparam logic [31:0] MEM_START_ADDRESS = 32'h0100_0000;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_READ,
      ST_WRITE,
      ST_RESP
   } state_t;

   // 2'b11 decodes as a word access.
   function automatic logic is_word(input logic [1:0] size);
      return size[1];
   endfunction

   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
      return is_word(size) ? (addr_lo != 2'b00) : ((size == SIZE_HALF) && addr_lo[0]);
   endfunction

endpackage

// File: rtl/mem_access_align.sv
// Load extension and sub-word store merge; the memory returns the addressed byte in
// bits [7:0], so no lane shifting is needed.
module mem_access_align
   import mem_access_pkg::*;
(
   input  logic [1:0]  size,
   input  logic        zero_ext,
   input  logic [31:0] raw,
   input  logic [31:0] wdata,
   output logic [31:0] load_data,
   output logic [31:0] store_data
);

   logic sign_b;
   logic sign_h;

   assign sign_b = raw[7] & ~zero_ext;
   assign sign_h = raw[15] & ~zero_ext;

   always_comb begin
      load_data  = raw;
      store_data = wdata;
      case (size)
         SIZE_BYTE: begin
            load_data  = {{24{sign_b}}, raw[7:0]};
            store_data = {raw[31:8], wdata[7:0]};
         end
         SIZE_HALF: begin
            load_data  = {{16{sign_h}}, raw[15:0]};
            store_data = {raw[31:16], wdata[15:0]};
         end
         SIZE_WORD: begin
            load_data  = raw;
            store_data = wdata;
         end
         default: begin
            load_data  = raw;
            store_data = wdata;
         end
      endcase
   end

endmodule

// File: rtl/mem_access_master.sv
// Load/store initiator owning the byte-addressed memory port.
// Optional misalignment trap: MEM_ACCESS_MISALIGN_CHECK_EN.
//
// state    | meaning
// ST_IDLE  | ready for a request, memory port quiet
// ST_READ  | memory addressed for a load or the old word of a sub-word store
// ST_WRITE | one-cycle write of the full or merged word
// ST_RESP  | one-cycle completion pulse
module mem_access_master
   import mem_access_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [1:0]        req_size,
   input  logic              req_unsigned,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_error,
   output logic [ADDR_W-1:0] mem_address,
   output logic [DATA_W-1:0] mem_data_in,
   output logic              mem_w_enable,
   input  logic [DATA_W-1:0] mem_data_out
);

   state_t      state;
   state_t      state_nxt;
   logic        accept;
   logic        misalign;
   logic        lat_write;
   logic [1:0]  lat_size;
   logic        lat_zext;
   logic [DATA_W-1:0] lat_wdata;
   logic [DATA_W-1:0] load_data;
   logic [DATA_W-1:0] store_data;

   assign accept = (state == ST_IDLE) && req_valid;

`ifdef MEM_ACCESS_MISALIGN_CHECK_EN
   logic err_q;

   assign misalign  = is_misaligned(req_size, req_addr[1:0]);
   assign rsp_error = (state == ST_RESP) && err_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         err_q <= 1'b0;
      end else if (accept) begin
         err_q <= misalign;
      end
   end
`else
   assign misalign  = 1'b0;
   assign rsp_error = 1'b0;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (req_valid) begin
               if (misalign) begin
                  state_nxt = ST_RESP;
               end else if (req_write && is_word(req_size)) begin
                  state_nxt = ST_WRITE;
               end else begin
                  state_nxt = ST_READ;
               end
            end
         end
         ST_READ:  state_nxt = lat_write ? ST_WRITE : ST_RESP;
         ST_WRITE: state_nxt = ST_RESP;
         ST_RESP:  state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   // Moore outputs; the write strobe clears asynchronously with the state register.
   assign req_ready    = (state == ST_IDLE);
   assign rsp_valid    = (state == ST_RESP);
   assign mem_w_enable = (state == ST_WRITE);

   mem_access_align u_align (
      .size       (lat_size),
      .zero_ext   (lat_zext),
      .raw        (mem_data_out),
      .wdata      (lat_wdata),
      .load_data  (load_data),
      .store_data (store_data)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         lat_write   <= 1'b0;
         lat_size    <= SIZE_BYTE;
         lat_zext    <= 1'b0;
         lat_wdata   <= '0;
         mem_address <= '0;
         mem_data_in <= '0;
         rsp_rdata   <= '0;
      end else begin
         if (accept) begin
            lat_write <= req_write;
            lat_size  <= req_size;
            lat_zext  <= req_unsigned;
            lat_wdata <= req_wdata;
            // a trapped request leaves the memory port untouched
            if (!misalign) begin
               mem_address <= req_addr;
            end else begin
               rsp_rdata <= '0;
            end
            if (req_write && is_word(req_size)) begin
               mem_data_in <= req_wdata;
            end
         end
         if (state == ST_READ) begin
            if (lat_write) begin
               mem_data_in <= store_data;
            end else begin
               rsp_rdata <= load_data;
            end
         end
         if (state == ST_WRITE) begin
            rsp_rdata <= '0;
         end
      end
   end

endmodule

// File: tb/tb_mem_access_master.sv
// Self-checking bench for mem_access_master: directed vector table, reset-abort
// sequence and randomized traffic against a byte-array reference model.
module tb_mem_access_master;
   import mem_access_pkg::*;

   logic        clk;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_error;
   logic [31:0] mem_address;
   logic [31:0] mem_data_in;
   logic        mem_w_enable;
   logic [31:0] mem_data_out;

   logic [7:0]  mem     [0:255];
   logic [7:0]  ref_mem [0:255];
   logic [31:0] wr_addr;
   logic [31:0] a0, a1, a2, a3;

   int n_checks;
   int n_fail;

   localparam logic [31:0] BASE = MEM_START_ADDRESS;

   mem_access_master #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk          (clk),
      .reset        (reset),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_write    (req_write),
      .req_size     (req_size),
      .req_unsigned (req_unsigned),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .rsp_valid    (rsp_valid),
      .rsp_rdata    (rsp_rdata),
      .rsp_error    (rsp_error),
      .mem_address  (mem_address),
      .mem_data_in  (mem_data_in),
      .mem_w_enable (mem_w_enable),
      .mem_data_out (mem_data_out)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Byte-addressed memory: a 256-byte window at BASE, combinational read.
   assign a0 = mem_address;
   assign a1 = mem_address + 32'd1;
   assign a2 = mem_address + 32'd2;
   assign a3 = mem_address + 32'd3;
   assign mem_data_out = {(a3[31:8] == BASE[31:8]) ? mem[a3[7:0]] : 8'h00,
                          (a2[31:8] == BASE[31:8]) ? mem[a2[7:0]] : 8'h00,
                          (a1[31:8] == BASE[31:8]) ? mem[a1[7:0]] : 8'h00,
                          (a0[31:8] == BASE[31:8]) ? mem[a0[7:0]] : 8'h00};

   function automatic logic [7:0] init_byte(input int i);
      logic [31:0] w;
      w = 32'h8BAD_F00D;
      if (i < 4) return w[8*i +: 8];
      return 8'(i * 37 + 11);
   endfunction

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = init_byte(i);
      forever begin
         @(posedge clk);
         if (mem_w_enable) begin
            for (int k = 0; k < 4; k++) begin
               wr_addr = mem_address + 32'(k);
               if (wr_addr[31:8] == BASE[31:8]) mem[wr_addr[7:0]] <= mem_data_in[8*k +: 8];
            end
         end
      end
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic logic [7:0] ref_byte(input logic [31:0] a);
      return ref_mem[a[7:0]];
   endfunction

   // Reference model: bytes in, bytes out, extension done numerically.
   task automatic model_access(input logic w, input logic [1:0] sz, input logic u,
                               input logic [31:0] a, input logic [31:0] wd,
                               output logic [31:0] rd, output logic err, output int lat,
                               output int wen, output logic [31:0] wword);
      int nb;
      bit mis;
      longint unsigned word, v, span;
      logic [31:0] ba;
      logic [7:0]  b;
      nb  = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
      mis = 1'b0;
`ifdef MEM_ACCESS_MISALIGN_CHECK_EN
      mis = (a % nb) != 0;
`endif
      rd = 32'd0; err = 1'b0; wword = 32'd0; wen = 0; lat = 1;
      if (mis) begin
         err = 1'b1;
         lat = 0;
         return;
      end
      word = 0;
      for (int k = 0; k < 4; k++) word += longint'(ref_byte(a + 32'(k))) << (8 * k);
      span = 64'd1 << (8 * nb);
      if (!w) begin
         v = word % span;
         if (!u && nb < 4 && v >= span / 2) v = v + (64'd1 << 32) - span;
         rd = v[31:0];
      end else begin
         for (int k = 0; k < 4; k++) begin
            ba = a + 32'(k);
            b  = (k < nb) ? wd[8*k +: 8] : ref_mem[ba[7:0]];
            wword[8*k +: 8] = b;
            ref_mem[ba[7:0]] = b;
         end
         wen = 1;
         lat = (nb < 4) ? 2 : 1;
      end
   endtask

   task automatic do_req(input logic w, input logic [1:0] sz, input logic u,
                         input logic [31:0] a, input logic [31:0] wd,
                         output logic [31:0] rd, output logic err, output int lat,
                         output int wen_cnt, output logic [31:0] wword, output int rdy_low);
      int n;
      bit got;
      n = 0;
      while (!req_ready && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      req_valid = 1'b1; req_write = w; req_size = sz; req_unsigned = u;
      req_addr  = a;    req_wdata = wd;
      @(posedge clk); #1;
      // scramble request fields so only latched values can be used
      req_valid = 1'b0; req_write = 1'($urandom); req_size = 2'($urandom);
      req_unsigned = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
      lat = -1; wen_cnt = 0; rdy_low = 0; got = 1'b0; rd = 32'd0; err = 1'b0; wword = 32'd0;
      for (int i = 0; i < 12 && !got; i++) begin
         if (mem_w_enable) begin
            wen_cnt++;
            wword = mem_data_in;
         end
         if (!req_ready) rdy_low++;
         if (rsp_valid) begin
            got = 1'b1;
            lat = i;
            rd  = rsp_rdata;
            err = rsp_error;
         end else begin
            @(posedge clk); #1;
         end
      end
      @(posedge clk); #1;
      check("rsp_single_pulse", 32'(rsp_valid), 32'd0);
      check("ready_after_resp", 32'(req_ready), 32'd1);
      check("rdata_held", rsp_rdata, rd);
      check("wen_idle", 32'(mem_w_enable), 32'd0);
   endtask

   task automatic run_one(input string nm, input logic w, input logic [1:0] sz, input logic u,
                          input logic [31:0] a, input logic [31:0] wd,
                          output logic [31:0] d_rd, output int d_lat, output logic [31:0] d_ww);
      logic [31:0] m_rd, m_ww, addr_before;
      logic        m_err, d_err;
      int          m_lat, m_wen, d_wen, d_rlow;
      model_access(w, sz, u, a, wd, m_rd, m_err, m_lat, m_wen, m_ww);
      addr_before = mem_address;
      do_req(w, sz, u, a, wd, d_rd, d_err, d_lat, d_wen, d_ww, d_rlow);
      check({nm, "_rdata"}, d_rd, m_rd);
      check({nm, "_error"}, 32'(d_err), 32'(m_err));
      check({nm, "_latency"}, d_lat, m_lat);
      check({nm, "_wen_cycles"}, d_wen, m_wen);
      check({nm, "_ready_low"}, d_rlow, m_lat + 1);
      if (m_wen != 0) check({nm, "_wdata"}, d_ww, m_ww);
      if (m_err) check({nm, "_addr_kept"}, mem_address, addr_before);
   endtask

   task automatic check_reset_values(input string nm);
      check({nm, "_ready"}, 32'(req_ready), 32'd1);
      check({nm, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
      check({nm, "_rsp_rdata"}, rsp_rdata, 32'd0);
      check({nm, "_rsp_error"}, 32'(rsp_error), 32'd0);
      check({nm, "_mem_address"}, mem_address, 32'd0);
      check({nm, "_mem_data_in"}, mem_data_in, 32'd0);
      check({nm, "_mem_w_enable"}, 32'(mem_w_enable), 32'd0);
   endtask

   typedef struct {
      logic        w;
      logic [1:0]  sz;
      logic        u;
      logic [31:0] a;
      logic [31:0] wd;
      logic [31:0] exp_rd;
      int          exp_lat;
      logic [31:0] exp_ww;
   } vec_t;

   vec_t tbl [13];

   initial begin
      logic [31:0] d_rd, d_ww;
      int          d_lat, cnt;

      n_checks = 0; n_fail = 0;
      for (int i = 0; i < 256; i++) ref_mem[i] = init_byte(i);

      tbl[0]  = '{1'b0, 2'd0, 1'b0, BASE + 32'd1, 32'd0,          32'hFFFF_FFF0, 1, 32'd0};
      tbl[1]  = '{1'b0, 2'd0, 1'b1, BASE + 32'd1, 32'd0,          32'h0000_00F0, 1, 32'd0};
      tbl[2]  = '{1'b0, 2'd1, 1'b0, BASE + 32'd2, 32'd0,          32'hFFFF_8BAD, 1, 32'd0};
      tbl[3]  = '{1'b0, 2'd2, 1'b0, BASE,         32'd0,          32'h8BAD_F00D, 1, 32'd0};
      tbl[4]  = '{1'b1, 2'd0, 1'b0, BASE,         32'h1234_5655,  32'd0,         2, 32'h8BAD_F055};
      tbl[5]  = '{1'b0, 2'd2, 1'b0, BASE,         32'd0,          32'h8BAD_F055, 1, 32'd0};
      tbl[6]  = '{1'b1, 2'd2, 1'b0, BASE + 32'd4, 32'hDEAD_BEEF,  32'd0,         1, 32'hDEAD_BEEF};
`ifdef MEM_ACCESS_MISALIGN_CHECK_EN
      tbl[7]  = '{1'b0, 2'd2, 1'b0, BASE + 32'd2, 32'd0,          32'd0,         0, 32'd0};
`else
      tbl[7]  = '{1'b0, 2'd2, 1'b0, BASE + 32'd2, 32'd0,          32'hBEEF_8BAD, 1, 32'd0};
`endif
      tbl[8]  = '{1'b0, 2'd1, 1'b1, BASE + 32'd6, 32'd0,          32'h0000_DEAD, 1, 32'd0};
      tbl[9]  = '{1'b0, 2'd0, 1'b0, BASE + 32'd5, 32'd0,          32'hFFFF_FFBE, 1, 32'd0};
      tbl[10] = '{1'b1, 2'd1, 1'b0, BASE + 32'd4, 32'h1234_ABCD,  32'd0,         2, 32'hDEAD_ABCD};
      tbl[11] = '{1'b0, 2'd2, 1'b0, BASE + 32'd4, 32'd0,          32'hDEAD_ABCD, 1, 32'd0};
      tbl[12] = '{1'b0, 2'd3, 1'b0, BASE,         32'd0,          32'h8BAD_F055, 1, 32'd0};

      reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0;
      req_unsigned = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
      #1;
      check_reset_values("reset");
      repeat (2) @(posedge clk);
      @(negedge clk) reset = 1'b0;
      @(posedge clk); #1;
      check("ready_after_release", 32'(req_ready), 32'd1);

      for (int i = 0; i < 13; i++) begin
         run_one($sformatf("vec%0d", i), tbl[i].w, tbl[i].sz, tbl[i].u, tbl[i].a, tbl[i].wd,
                 d_rd, d_lat, d_ww);
         check($sformatf("vec%0d_tbl_rdata", i), d_rd, tbl[i].exp_rd);
         check($sformatf("vec%0d_tbl_latency", i), d_lat, tbl[i].exp_lat);
         if (tbl[i].w) check($sformatf("vec%0d_tbl_wdata", i), d_ww, tbl[i].exp_ww);
      end

      // Reset lands while a half store is in WRITE: nothing may commit.
      req_valid = 1'b1; req_write = 1'b1; req_size = 2'd1; req_unsigned = 1'b0;
      req_addr = BASE + 32'd16; req_wdata = 32'h0000_CAFE;
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(posedge clk); #1;
      check("abort_wen_before_reset", 32'(mem_w_enable), 32'd1);
      #1 reset = 1'b1;
      #1;
      check_reset_values("abort");
      @(posedge clk);
      @(negedge clk) reset = 1'b0;
      cnt = 0;
      repeat (4) begin
         @(posedge clk); #1;
         if (rsp_valid || mem_w_enable) cnt++;
      end
      check("abort_no_activity", cnt, 0);
      check("abort_ready", 32'(req_ready), 32'd1);
      cnt = 0;
      for (int k = 16; k < 20; k++) if (mem[k] !== ref_mem[k]) cnt++;
      check("abort_mem_unchanged", cnt, 0);

      for (int i = 0; i < 60; i++) begin
         run_one($sformatf("rnd%0d", i), 1'($urandom), 2'($urandom), 1'($urandom),
                 BASE + 32'($urandom_range(0, 60)), $urandom, d_rd, d_lat, d_ww);
      end

      cnt = 0;
      for (int k = 0; k < 256; k++) if (mem[k] !== ref_mem[k]) cnt++;
      check("final_memory_image", cnt, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_access_master.md
# mem_access_master

Load/store initiator that drives the CPU's byte-addressed unified memory port (`address`, `data_in`, `w_enable`, `data_out`). It accepts one load or store request at a time from the pipeline, performs sign/zero extension for sub-word loads, and performs read-modify-write for sub-word stores. The memory always writes 4 bytes starting at `address` and reads combinationally when `w_enable` is low, so this block owns every memory-port cycle between the datapath and the memory.

## Interface
- Parameters:
  - `ADDR_W`, 32, address width.
  - `DATA_W`, 32, data width; fixed at 32.
- Ports:
  - `clk` in 1: single clock.
  - `reset` in 1: asynchronous, active-high.
  - `req_valid` in 1: request present.
  - `req_ready` out 1: block idle; the request is accepted on a clock edge where `req_valid` and `req_ready` are both high.
  - `req_write` in 1: 1 = store, 0 = load.
  - `req_size` in 2: 00 = byte, 01 = half, 10 = word; 11 is treated as word.
  - `req_unsigned` in 1: zero-extend loads.
  - `req_addr` in 32: byte address.
  - `req_wdata` in 32: store data; the low bytes are used for sub-word stores.
  - `rsp_valid` out 1: one-cycle completion pulse for both loads and stores.
  - `rsp_rdata` out 32: extended load data; 0 for stores.
  - `rsp_error` out 1: misaligned request; see Configuration.
  - `mem_address` out 32: to memory `address`.
  - `mem_data_in` out 32: to memory `data_in`.
  - `mem_w_enable` out 1: to memory `w_enable`.
  - `mem_data_out` in 32: from memory `data_out`.

## Operation
- FSM states: IDLE, READ, WRITE, RESP.
- Request fields are latched on acceptance.
- IDLE:
  - `req_ready` = 1; `mem_w_enable` = 0.
  - `mem_address` holds its last value.
- Load: IDLE → READ → RESP → IDLE.
  - In READ, `mem_address` = latched address and `mem_w_enable` = 0.
  - `mem_data_out` is sampled at the end of READ.
- Word store: IDLE → WRITE → RESP → IDLE.
- Byte/half store: IDLE → READ → WRITE → RESP → IDLE.
  - The old word is read at the same address.
  - The low 1 or 2 bytes are replaced with `req_wdata`; the upper bytes keep their read values.
  - The merged word is written back.
- WRITE:
  - `mem_w_enable` = 1 for exactly one cycle.
  - `mem_data_in` = the full or merged word.
- Byte lanes: the memory returns the byte at `address` in bits [7:0], so there is no lane shifting.
  - Byte load: extend `data[7:0]`.
  - Half load: extend `data[15:0]`.
  - Signed loads replicate bit 7 or bit 15; unsigned loads zero-fill.
- RESP:
  - `rsp_valid` = 1 for one cycle.
  - `rsp_rdata` = extended data for loads, 0 for stores.
  - `rsp_rdata` is held until the next RESP.
- There is no response back-pressure; the consumer must take `rsp_valid` when it is high.
- `req_ready` = 0 in every state except IDLE.

## Timing
- Acceptance edge E0.
- Load: `rsp_valid` high during E1–E2.
- Word store: write committed at E1; `rsp_valid` high during E1–E2.
- Sub-word store: old word sampled at E1, write committed at E2; `rsp_valid` high during E2–E3.
- The next request can be accepted at the edge that ends RESP.
- Outputs are Moore-decoded from the state and latched registers. No combinational path runs from `req_*` to `mem_*`.
- Reset values:
  - State IDLE, `req_ready` = 1.
  - `rsp_valid` = 0, `rsp_rdata` = 0, `rsp_error` = 0.
  - `mem_address` = 0, `mem_data_in` = 0, `mem_w_enable` = 0.
- Reset asserted mid-operation:
  - `mem_w_enable` drops immediately, so no write commits if reset precedes the WRITE edge.
  - The in-flight request is dropped with no response.
- Address arithmetic wraps modulo 2^32.

## Configuration
- Macro: `MEM_ACCESS_MISALIGN_CHECK_EN`.
- Defined:
  - Half requests with `addr[0]` = 1, and word requests with `addr[1:0]` ≠ 0, go IDLE → RESP.
  - `rsp_valid` and `rsp_error` are 1 at E1; `rsp_rdata` = 0.
  - Memory is not touched: `mem_w_enable` stays 0 and `mem_address` is unchanged.
- Undefined:
  - `rsp_error` is tied to 0.
  - Misaligned accesses proceed normally, because the memory is byte-addressed and handles them natively.

## Structure
- Package `mem_access_pkg` holds:
  - size encodings `SIZE_BYTE`, `SIZE_HALF`, `SIZE_WORD`;
  - the FSM state enum;
  - `MEM_START_ADDRESS` = 32'h01000000.
- Sub-module `mem_access_align` is purely combinational. It performs load extension and store merge, with inputs size, unsigned, raw word, and wdata.

## Test plan
All scenarios preload the word at 0x01000000 with 0x8BADF00D.
1. Load byte, signed, from 0x01000001 → `rsp_rdata` = 0xFFFFFFF0 at E1. Unsigned → 0x000000F0. `mem_w_enable` never asserts.
2. Load half, signed, from 0x01000002 → 0xFFFF8BAD. Load word from 0x01000000 → 0x8BADF00D.
3. Store byte 0x55 to 0x01000000 → `mem_w_enable` is high for exactly one cycle (E1–E2) with `mem_data_in` = 0x8BADF055. `rsp_valid` at E2. A reload returns 0x8BADF055.
4. Store word 0xDEADBEEF to 0x01000004 → write at E1, `rsp_valid` at E1. `req_ready` is low for exactly 2 cycles. Back-to-back requests are accepted at the first IDLE edge.
5. Word load at 0x01000002:
   - With the macro: `rsp_error` = 1 at E1, no memory cycle.
   - Without the macro: returns bytes 2..5 of memory.
6. Assert `reset` during the WRITE of a half store → `mem_w_enable` falls immediately and memory is unchanged. All outputs take their reset values; `req_ready` = 1 after release.
